// File: rtl/star_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two burst-read
// requesters and steers each returned byte back to the requester that owns the burst.
module star_mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_base,
    input  logic [LEN_W-1:0]  req0_len_m1,
    output logic              req0_grant,
    output logic              req0_data_valid,
    output logic              req0_done,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_base,
    input  logic [LEN_W-1:0]  req1_len_m1,
    output logic              req1_grant,
    output logic              req1_data_valid,
    output logic              req1_done,

    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    // Handshake: reqN_valid is held with stable base/len until the one-cycle reqN_grant,
    // which is only raised in IDLE; base/len are sampled on that edge and may change after.
    // A requester may drop valid before it is granted.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic                rd_pipe_valid_q;
    logic                rd_pipe_owner_q;

    logic                winner;
    logic                any_valid;

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = rr_ptr_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Grants are suppressed while reset is held so nothing is sampled that reset discards.
    assign any_valid = (req0_valid || req1_valid) && !reset;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        req0_grant  = 1'b0;
        req1_grant  = 1'b0;
        mem_req     = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req0_grant  = !winner;
                    req1_grant  = winner;
                    owner_d     = winner;
                    cur_addr_d  = winner ? req1_base : req0_base;
                    remaining_d = winner ? req1_len_m1 : req0_len_m1;
                    state_d     = BURST;
                end
            end
            BURST: begin
                mem_req     = 1'b1;
                cur_addr_d  = cur_addr_q + ADDR_ONE;
                remaining_d = remaining_q - LEN_ONE;
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last byte is returning now; hand priority to the other requester.
                rr_ptr_d = ~owner_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= 1'b0;
            owner_q         <= 1'b0;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            rd_pipe_valid_q <= 1'b0;
            rd_pipe_owner_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            rd_pipe_valid_q <= mem_req;
            rd_pipe_owner_q <= owner_q;
        end
    end

    assign mem_addr        = cur_addr_q;
    assign rd_data         = mem_data;
    assign busy            = (state_q != IDLE);
    assign req0_data_valid = rd_pipe_valid_q && !rd_pipe_owner_q;
    assign req1_data_valid = rd_pipe_valid_q && rd_pipe_owner_q;
    // The only byte returning while in DRAIN is the final one of the burst.
    assign req0_done       = req0_data_valid && (state_q == DRAIN);
    assign req1_done       = req1_data_valid && (state_q == DRAIN);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(req0_grant && req1_grant))
                else $error("both grants asserted");
            assert (!(req0_data_valid && req1_data_valid))
                else $error("both data_valid asserted");
            assert (!(req0_done && req1_done))
                else $error("both done asserted");
            assert (!((req0_grant || req1_grant) && state_q != IDLE))
                else $error("grant outside IDLE");
        end
    end
`endif

endmodule

// File: doc/star_mem_arbiter.md
Name: star_mem_arbiter

Overview:
- Shares the single-port 512x8 image data memory between two burst-read requesters, for example the STAR input loader and a debug/readback engine.
- Accepts one burst of 1..16 bytes at a time, chosen by round-robin. Drives the memory request/address and steers returned bytes to the owning requester with valid and done strobes.
- Sits between the requesters and the data memory interface (data_req / data_addr / data).

Parameters:
ADDR_W, 9, memory address width
DATA_W, 8, memory data width
LEN_W, 4, burst length field width; a burst is len_m1+1 bytes

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 burst request; held until granted
req0_base  input  ADDR_W  requester 0 start address
req0_len_m1  input  LEN_W  requester 0 burst length minus one
req0_grant  output  1  one-cycle pulse: burst accepted, base/len sampled
req0_data_valid  output  1  rd_data belongs to requester 0 this cycle
req0_done  output  1  one-cycle pulse with requester 0's last byte
req1_valid  input  1  requester 1 burst request
req1_base  input  ADDR_W  requester 1 start address
req1_len_m1  input  LEN_W  requester 1 burst length minus one
req1_grant  output  1  requester 1 grant pulse
req1_data_valid  output  1  rd_data belongs to requester 1
req1_done  output  1  requester 1 last-byte pulse
rd_data  output  DATA_W  returned byte; equals mem_data
mem_req  output  1  memory read request (data_req)
mem_addr  output  ADDR_W  memory read address (data_addr)
mem_data  input  DATA_W  memory read data, valid one cycle after mem_req/mem_addr
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, BURST, DRAIN. Reset forces IDLE.
- Reset clears rr_ptr, owner, cur_addr, remaining and rd_pipe_valid. Every output is 0 after reset; rd_data follows mem_data.
- IDLE, winner selection:
  - Only one reqN_valid: that requester wins.
  - Both valid: the requester indexed by rr_ptr wins; rr_ptr is 0 after reset.
- IDLE, grant:
  - reqN_grant is asserted combinationally in the same cycle.
  - On that edge: owner<=N, cur_addr<=reqN_base, remaining<=reqN_len_m1, state goes to BURST.
  - With no valid, stay in IDLE. A requester may drop valid before it is granted (withdraw).
- BURST, each cycle:
  - mem_req=1 and mem_addr=cur_addr.
  - cur_addr increments modulo 2^ADDR_W, so 511 wraps to 0.
  - remaining decrements.
  - When remaining==0, this cycle's address is the last one; next state is DRAIN.
- DRAIN:
  - mem_req=0.
  - The last byte returns; reqN_done pulses together with the final reqN_data_valid.
  - rr_ptr<=~owner, so the other requester has priority next. Next state is IDLE.
- Data return:
  - rd_pipe_valid<=mem_req and rd_pipe_owner<=owner, each registered.
  - reqN_data_valid = rd_pipe_valid & (rd_pipe_owner==N).
  - Bytes arrive in address order, exactly len_m1+1 of them.
- Timing: grant at T0; addresses at T1..T(L); data_valid at T2..T(L+1); done at T(L+1); IDLE at T(L+2), where L = len_m1+1. Cost per burst is L+2 cycles.
- A grant is never issued outside IDLE. Requests arriving during BURST/DRAIN wait.
- reqN_base/len changes after grant have no effect on the burst in flight.
- mem_addr holds its last value when mem_req=0; it is not required to be meaningful then.
- Reset asserted mid-burst: the next edge returns to IDLE with all strobes 0. In-flight data is discarded, with no data_valid and no done. rr_ptr returns to 0.
- Exactly one of req0_data_valid/req1_data_valid may be high in a cycle. Grant, done and data_valid for requester 0 and requester 1 are mutually exclusive.

Test Plan:
- req0 base=0x000, len_m1=15, memory returns addr[7:0]. Required: grant0 at T0; mem_addr 0..15 at T1..T16; data_valid0 with rd_data 0x00..0x0F at T2..T17; done0 at T17; busy low at T18.
- req0 and req1 both valid from reset (bases 0x010/0x100, len_m1=3). Required: req0 served first, then req1 granted at the next IDLE. With both held continuously, grants alternate 0,1,0,1.
- req1 base=0x1FE, len_m1=3. Required: mem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; four data_valid1 pulses; done1 on the fourth.
- len_m1=0 from req1. Required: one mem_req cycle, one data_valid1, and done1 in the same cycle; total 3 cycles grant-to-IDLE.
- reset asserted in the 3rd BURST cycle of a 16-byte burst. Required: next cycle mem_req=0, busy=0, and no data_valid/done. A fresh req1 is granted immediately after reset deasserts.
- req0_valid pulsed for one cycle while BURST is serving req1, then dropped. Required: no grant0 ever, and the arbiter returns to IDLE idle.
